mesh_router: RTL and testbench

Five-port input-queued packet router for one node of the 2-D mesh NoC. Each packet is a single `packet_t` flit. Packets arriving on the local port or on any of the four neighbour ports are buffered per input and routed dimension-order (X then Y). They are switched to one output per cycle under a round-robin allocator, with per-port enable flow control. One instance sits at every mesh coordinate (`X_LOC`, `Y_LOC`).

---
 rtl/noc_pkg.sv | 41 ++++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/mesh_router.sv | 111 +++++++++++
 tb/tb_mesh_router.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC types: packet flit layout, mesh constants, port indices and the
// dimension-order routing rule used by every router instance.
package noc_pkg;

  localparam int X_NODES   = 4;
  localparam int Y_NODES   = 4;
  localparam int NODES     = (X_NODES > Y_NODES) ? X_NODES : Y_NODES;
  localparam int COORD_W   = $clog2(NODES + 1);
  localparam int NUM_PORTS = 5;
  localparam int PORT_W    = 3;

  localparam logic [PORT_W-1:0] PORT_LOCAL = 3'd0;
  localparam logic [PORT_W-1:0] PORT_YP    = 3'd1;
  localparam logic [PORT_W-1:0] PORT_XP    = 3'd2;
  localparam logic [PORT_W-1:0] PORT_YM    = 3'd3;
  localparam logic [PORT_W-1:0] PORT_XM    = 3'd4;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [7:0]  id;
    coord_t      x_source;
    coord_t      y_source;
    coord_t      x_dest;
    coord_t      y_dest;
    logic        ant;
    logic        measure;
    logic [15:0] timestamp;
  } packet_t;

  // X is resolved completely before Y; a packet at its destination ejects locally.
  function automatic logic [PORT_W-1:0] route_port(input coord_t x_dest, input coord_t y_dest,
                                                   input coord_t x_here, input coord_t y_here);
    if (x_dest > x_here) return PORT_XP;
    if (x_dest < x_here) return PORT_XM;
    if (y_dest > y_here) return PORT_YP;
    if (y_dest < y_here) return PORT_YM;
    return PORT_LOCAL;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Five-request round-robin arbiter; search starts at the pointer, and the
// pointer advances to one past the winner only when something is granted.
module rr_arbiter
  import noc_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] grant_o
);

  localparam logic [PORT_W:0]   NP   = (PORT_W+1)'(NUM_PORTS);
  localparam logic [PORT_W-1:0] LAST = PORT_W'(NUM_PORTS - 1);

  logic [PORT_W-1:0] ptr_q, ptr_d;
  logic [PORT_W-1:0] cand;
  logic [PORT_W:0]   sum;
  logic              found;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    cand    = '0;
    sum     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum  = {1'b0, ptr_q} + (PORT_W+1)'(i);
      cand = (sum >= NP) ? PORT_W'(sum - NP) : PORT_W'(sum);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        ptr_d         = (cand == LAST) ? '0 : cand + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mesh_router.sv
// Five-port input-queued mesh router: per-input FIFOs, X-then-Y routing,
// one round-robin arbiter per output and a registered crossbar output stage.
module mesh_router
  import noc_pkg::*;
#(
  parameter int X_LOC       = 0,
  parameter int Y_LOC       = 0,
  parameter int X_NODES     = 4,
  parameter int Y_NODES     = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  packet_t [NUM_PORTS-1:0] i_data,
  input  logic    [NUM_PORTS-1:0] i_data_val,
  output logic    [NUM_PORTS-1:0] o_en,
  output packet_t [NUM_PORTS-1:0] o_data,
  output logic    [NUM_PORTS-1:0] o_data_val,
  input  logic    [NUM_PORTS-1:0] i_en
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam coord_t X_HERE = coord_t'(X_LOC % X_NODES);
  localparam coord_t Y_HERE = coord_t'(Y_LOC % Y_NODES);

  packet_t           fifo_mem_q [NUM_PORTS][QUEUE_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q   [NUM_PORTS];
  logic [PTR_W-1:0]  rd_ptr_q   [NUM_PORTS];
  logic [CNT_W-1:0]  count_q    [NUM_PORTS];

  packet_t           head       [NUM_PORTS];
  logic [PORT_W-1:0] head_dir   [NUM_PORTS];
  logic [NUM_PORTS-1:0] not_empty, push, pop;
  logic [NUM_PORTS-1:0] req      [NUM_PORTS];
  logic [NUM_PORTS-1:0] grant    [NUM_PORTS];
  packet_t           win_data   [NUM_PORTS];

  packet_t [NUM_PORTS-1:0] o_data_q;
  logic    [NUM_PORTS-1:0] o_data_val_q;

  // o_en looks only at occupancy, so a full FIFO refuses a push even if it pops this cycle.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      not_empty[p] = (count_q[p] != '0);
      o_en[p]      = (count_q[p] < DEPTH_C);
      push[p]      = i_data_val[p] && o_en[p];
      head[p]      = fifo_mem_q[p][rd_ptr_q[p]];
      head_dir[p]  = route_port(head[p].x_dest, head[p].y_dest, X_HERE, Y_HERE);
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        req[o][p] = not_empty[p] && (head_dir[p] == PORT_W'(o)) && i_en[o];
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter u_arb (
      .clk     (clk),
      .reset   (reset),
      .req_i   (req[o]),
      .grant_o (grant[o])
    );
  end

  // Each input requests a single output, so OR-ing grants yields a one-hot-per-input pop.
  always_comb begin
    pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      win_data[o] = '0;
      pop         = pop | grant[o];
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant[o][p]) win_data[o] = head[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        count_q[p]  <= '0;
      end
      o_data_q     <= '0;
      o_data_val_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push[p]) begin
          fifo_mem_q[p][wr_ptr_q[p]] <= i_data[p];
          wr_ptr_q[p]                <= wr_ptr_q[p] + 1'b1;
        end
        if (pop[p]) rd_ptr_q[p] <= rd_ptr_q[p] + 1'b1;
        count_q[p] <= count_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
        o_data_val_q[o] <= |grant[o];
        if (|grant[o]) o_data_q[o] <= win_data[o];
      end
    end
  end

  assign o_data     = o_data_q;
  assign o_data_val = o_data_val_q;

endmodule

// File: tb/tb_mesh_router.sv
// Bench for mesh_router at (2,1): directed scenarios plus random traffic, all
// compared every cycle against a queue-based reference model of the router.
module tb_mesh_router;
  import noc_pkg::*;

  localparam int TB_X  = 2;
  localparam int TB_Y  = 1;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  packet_t [4:0] i_data;
  logic    [4:0] i_data_val, i_en, o_en, o_data_val;
  packet_t [4:0] o_data;

  mesh_router #(
    .X_LOC(TB_X), .Y_LOC(TB_Y), .X_NODES(4), .Y_NODES(4), .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_data     (i_data),
    .i_data_val (i_data_val),
    .o_en       (o_en),
    .o_data     (o_data),
    .o_data_val (o_data_val),
    .i_en       (i_en)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  packet_t mq [5][$];
  int      rr_ptr [5];
  logic [4:0] exp_val;
  packet_t exp_data [5];
  int      dut_emit [5];
  logic [63:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int model_route(packet_t pk);
    if (int'(pk.x_dest) > TB_X) return 2;
    if (int'(pk.x_dest) < TB_X) return 4;
    if (int'(pk.y_dest) > TB_Y) return 1;
    if (int'(pk.y_dest) < TB_Y) return 3;
    return 0;
  endfunction

  task automatic model_step();
    bit popped [5];
    bit accept [5];
    if (reset) begin
      for (int p = 0; p < 5; p++) begin
        mq[p].delete();
        rr_ptr[p]   = 0;
        exp_data[p] = '0;
      end
      exp_val = '0;
      return;
    end
    exp_val = '0;
    for (int p = 0; p < 5; p++) popped[p] = 0;
    for (int o = 0; o < 5; o++) begin
      bit found = 0;
      if (i_en[o]) begin
        for (int k = 0; k < 5; k++) begin
          int idx = (rr_ptr[o] + k) % 5;
          if (!found && mq[idx].size() > 0 && model_route(mq[idx][0]) == o) begin
            found       = 1;
            exp_val[o]  = 1'b1;
            exp_data[o] = mq[idx][0];
            popped[idx] = 1;
            rr_ptr[o]   = (idx + 1) % 5;
          end
        end
      end
    end
    for (int p = 0; p < 5; p++) accept[p] = i_data_val[p] && (mq[p].size() < DEPTH);
    for (int p = 0; p < 5; p++) begin
      if (popped[p]) void'(mq[p].pop_front());
      if (accept[p]) mq[p].push_back(i_data[p]);
    end
  endtask

  task automatic compare_all();
    for (int p = 0; p < 5; p++) begin
      check($sformatf("o_en[%0d]", p), 64'(o_en[p]), 64'(mq[p].size() < DEPTH));
      check($sformatf("o_data_val[%0d]", p), 64'(o_data_val[p]), 64'(exp_val[p]));
      check($sformatf("o_data[%0d]", p), 64'(o_data[p]), 64'(exp_data[p]));
      if (o_data_val[p]) dut_emit[p]++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    i_data_val = '0;
    i_data     = '0;
  endtask

  function automatic packet_t mk_pkt(int src, int xd, int yd);
    packet_t pk;
    pk.id        = 8'($urandom);
    pk.x_source  = coord_t'(src);
    pk.y_source  = coord_t'($urandom_range(0, 3));
    pk.x_dest    = coord_t'(xd);
    pk.y_dest    = coord_t'(yd);
    pk.ant       = 1'($urandom);
    pk.measure   = 1'($urandom);
    pk.timestamp = 16'($urandom);
    return pk;
  endfunction

  function automatic int total_emit();
    int s = 0;
    for (int p = 0; p < 5; p++) s += dut_emit[p];
    return s;
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    idle();
    cycle();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    packet_t pa, pb, pc;
    int got_src [$];
    int rot [6];
    int base;
    logic seen;
    rot = '{1, 3, 4, 1, 3, 4};
    for (int p = 0; p < 5; p++) dut_emit[p] = 0;
    reset = 1'b1;
    i_en  = '1;
    idle();

    // reset: two cycles, then first cycle after deassertion
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    check("rst_val", 64'(o_data_val), 64'(0));
    check("rst_data", 64'(o_data), 64'(0));
    check("rst_en", 64'(o_en), 64'(5'b11111));

    // single packet, X-first: local -> (3,3) leaves on output 2 two cycles later
    pa = mk_pkt(0, 3, 3);
    i_data[0] = pa;
    i_data_val = 5'b00001;
    cycle();
    idle();
    check("single_early", 64'(o_data_val), 64'(0));
    cycle();
    check("single_val", 64'(o_data_val), 64'(5'b00100));
    check("single_data", 64'(o_data[2]), 64'(pa));
    cycle();

    // ejection and Y routing
    pa = mk_pkt(4, 2, 1);
    pb = mk_pkt(3, 2, 3);
    pc = mk_pkt(1, 2, 0);
    i_data[4] = pa;
    i_data[3] = pb;
    i_data[1] = pc;
    i_data_val = 5'b11010;
    cycle();
    idle();
    cycle();
    check("ydir_val", 64'(o_data_val), 64'(5'b01011));
    check("eject_data", 64'(o_data[0]), 64'(pa));
    check("yplus_data", 64'(o_data[1]), 64'(pb));
    check("yminus_data", 64'(o_data[3]), 64'(pc));
    cycle();

    // contention on output 4 from inputs 1, 3, 4
    pulse_reset();
    base = dut_emit[4];
    for (int c = 0; c < 10; c++) begin
      i_data[1] = mk_pkt(1, 0, 0);
      i_data[3] = mk_pkt(3, 0, 0);
      i_data[4] = mk_pkt(4, 0, 0);
      i_data_val = 5'b11010;
      cycle();
      if (o_data_val[4]) got_src.push_back(int'(o_data[4].x_source));
    end
    idle();
    check("contend_count", 64'(dut_emit[4] - base), 64'(9));
    for (int i = 0; i < 6; i++)
      check($sformatf("contend_rot%0d", i), 64'((i < got_src.size()) ? got_src[i] : -1), 64'(rot[i]));
    for (int c = 0; c < 30; c++) cycle();

    // back-pressure on output 2
    pulse_reset();
    i_en = 5'b11011;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pa = mk_pkt(0, 3, 1);
      pa.id = 8'(k);
      if (k < 4) exp_q.push_back(64'(pa));
      i_data[0] = pa;
      i_data_val = 5'b00001;
      cycle();
      seen = seen | o_data_val[2];
      if (k == 2) check("bp_en_high", 64'(o_en[0]), 64'(1));
      if (k == 3) check("bp_en_low", 64'(o_en[0]), 64'(0));
    end
    idle();
    for (int c = 0; c < 3; c++) begin
      cycle();
      seen = seen | o_data_val[2];
    end
    check("bp_no_out", 64'(seen), 64'(0));
    i_en = '1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (o_data_val[2]) begin
        if (exp_q.size() == 0) check("bp_extra", 64'(o_data[2]), 64'(0));
        else check("bp_order", 64'(o_data[2]), exp_q.pop_front());
      end
    end
    check("bp_drained", 64'(exp_q.size()), 64'(0));

    // reset mid-flow discards buffered packets
    i_en = '0;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 3; p++) i_data[p] = mk_pkt(p, $urandom_range(0, 3), $urandom_range(0, 3));
      i_data_val = 5'b00111;
      cycle();
    end
    pulse_reset();
    i_en = '1;
    base = total_emit();
    for (int c = 0; c < 10; c++) cycle();
    check("rst_no_stale", 64'(total_emit()), 64'(base));

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < 5; p++) begin
        i_en[p] = ($urandom_range(0, 3) != 0);
        i_data[p] = mk_pkt(p, $urandom_range(0, 3), $urandom_range(0, 3));
        i_data_val[p] = 1'($urandom_range(0, 1));
        if (!o_en[p] && $urandom_range(0, 7) != 0) i_data_val[p] = 1'b0;
      end
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;
    idle();
    i_en = '1;
    for (int c = 0; c < 20; c++) cycle();

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
